// File: rtl/string_arbiter.sv
// Two-requester string arbiter: grants a whole string at a time, alternating under
// contention, truncating strings longer than MAX_LEN and discarding their remainder.
module string_arbiter #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in0_last,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [DATA_W-1:0] in1_data,
   input  logic              in1_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_src,
   output logic              busy,
   output logic              trunc,
   output logic [15:0]       str_cnt0,
   output logic [15:0]       str_cnt1
);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DROP} state_e;

   localparam logic [7:0] LEN_LAST = 8'(MAX_LEN - 1);

   state_e      state_q, state_d;
   logic        last_q, last_d;
   logic [7:0]  len_q, len_d;
   logic        trunc_q, trunc_d;
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   logic              gsrc;
   logic              sel_valid;
   logic [DATA_W-1:0] sel_data;
   logic              sel_last;
   logic              at_max;
   logic              done;

   // In DROP the truncated requester is the one recorded as last granted.
   assign gsrc      = (state_q == GRANT1) ? 1'b1 : (state_q == GRANT0) ? 1'b0 : last_q;
   assign sel_valid = gsrc ? in1_valid : in0_valid;
   assign sel_data  = gsrc ? in1_data  : in0_data;
   assign sel_last  = gsrc ? in1_last  : in0_last;
   assign at_max    = (len_q == LEN_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         len_q   <= '0;
         trunc_q <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         len_q   <= len_d;
         trunc_q <= trunc_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      len_d     = len_q;
      trunc_d   = 1'b0;
      done      = 1'b0;
      in0_ready = 1'b0;
      in1_ready = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_src   = last_q;

      case (state_q)
         IDLE: begin
            if (in0_valid && in1_valid) begin
               state_d = last_q ? GRANT0 : GRANT1;
               len_d   = '0;
            end else if (in0_valid) begin
               state_d = GRANT0;
               len_d   = '0;
            end else if (in1_valid) begin
               state_d = GRANT1;
               len_d   = '0;
            end
         end
         GRANT0, GRANT1: begin
            out_valid = sel_valid;
            out_data  = sel_data;
            out_last  = sel_last | at_max;
            out_src   = gsrc;
            in0_ready = ~gsrc & out_ready;
            in1_ready = gsrc & out_ready;
            if (sel_valid && out_ready) begin
               len_d = len_q + 8'd1;
               if (sel_last) begin
                  state_d = IDLE;
                  last_d  = gsrc;
                  done    = 1'b1;
               end else if (at_max) begin
                  state_d = DROP;
                  last_d  = gsrc;
                  trunc_d = 1'b1;
                  done    = 1'b1;
               end
            end
         end
         DROP: begin
            in0_ready = ~gsrc;
            in1_ready = gsrc;
            if (sel_valid && sel_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Hold the interface quiet while reset is asserted, even mid-string.
      if (rst) begin
         in0_ready = 1'b0;
         in1_ready = 1'b0;
         out_valid = 1'b0;
         out_last  = 1'b0;
         out_src   = 1'b1;
      end
   end

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (done) begin
         if (gsrc) cnt1_d = cnt1_q + 16'd1;
         else      cnt0_d = cnt0_q + 16'd1;
      end
   end

   assign busy     = ~rst & (state_q != IDLE);
   assign trunc    = trunc_q;
   assign str_cnt0 = cnt0_q;
   assign str_cnt1 = cnt1_q;

endmodule

// File: tb/tb_string_arbiter.sv
// Directed bench for string_arbiter: contention, alternation, truncation, stalls, reset.
module tb_string_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       in0_valid, in0_ready, in0_last;
   logic [7:0] in0_data;
   logic       in1_valid, in1_ready, in1_last;
   logic [7:0] in1_data;
   logic       out_valid, out_ready, out_last, out_src, busy, trunc;
   logic [7:0] out_data;
   logic [15:0] str_cnt0, str_cnt1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   string_arbiter #(.DATA_W(8), .MAX_LEN(16)) dut (
      .clk(clk), .rst(rst),
      .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
      .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .out_src(out_src), .busy(busy), .trunc(trunc),
      .str_cnt0(str_cnt0), .str_cnt1(str_cnt1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int n, input logic v, input logic [7:0] d, input logic l);
      if (n == 0) begin
         in0_valid = v; in0_data = d; in0_last = l;
      end else begin
         in1_valid = v; in1_data = d; in1_last = l;
      end
   endtask

   // Present one character from requester n with out_ready=1, check the forwarded beat, advance.
   task automatic send(input int n, input logic [7:0] d, input logic l, input logic exp_last,
                       input string tag);
      drv(n, 1'b1, d, l);
      #1;
      chk({tag, "_vld"},  32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(d));
      chk({tag, "_src"},  32'(out_src), 32'(n));
      chk({tag, "_last"}, 32'(out_last), 32'(exp_last));
      chk({tag, "_rdy"},  32'(n != 0 ? in1_ready : in0_ready), 32'd1);
      chk({tag, "_ordy"}, 32'(n != 0 ? in0_ready : in1_ready), 32'd0);
      tick();
   endtask

   initial begin
      rst = 1'b1; out_ready = 1'b1;
      drv(0, 1'b0, 8'h00, 1'b0);
      drv(1, 1'b0, 8'h00, 1'b0);
      tick(); tick();
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovld", 32'(out_valid), 32'd0);
      chk("rst_rdy0", 32'(in0_ready), 32'd0);
      chk("rst_src",  32'(out_src), 32'd1);
      chk("rst_trunc", 32'(trunc), 32'd0);
      chk("rst_cnt0", 32'(str_cnt0), 32'd0);
      chk("rst_cnt1", 32'(str_cnt1), 32'd0);
      rst = 1'b0;
      tick();
      #1;
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_src",  32'(out_src), 32'd1);
      chk("post_ovld", 32'(out_valid), 32'd0);

      // Simultaneous "abc" / "xyz": requester 0 first, bubble, then requester 1.
      drv(0, 1'b1, "a", 1'b0);
      drv(1, 1'b1, "x", 1'b0);
      #1;
      chk("t1_idle_ovld", 32'(out_valid), 32'd0);
      chk("t1_idle_rdy0", 32'(in0_ready), 32'd0);
      chk("t1_idle_rdy1", 32'(in1_ready), 32'd0);
      tick();
      send(0, "a", 1'b0, 1'b0, "t1a");
      send(0, "b", 1'b0, 1'b0, "t1b");
      send(0, "c", 1'b1, 1'b1, "t1c");
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t1_bub_busy", 32'(busy), 32'd0);
      chk("t1_bub_ovld", 32'(out_valid), 32'd0);
      chk("t1_bub_src",  32'(out_src), 32'd0);
      chk("t1_bub_rdy1", 32'(in1_ready), 32'd0);
      chk("t1_cnt0",     32'(str_cnt0), 32'd1);
      tick();
      send(1, "x", 1'b0, 1'b0, "t1x");
      send(1, "y", 1'b0, 1'b0, "t1y");
      send(1, "z", 1'b1, 1'b1, "t1z");
      drv(1, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t1_cnt1",    32'(str_cnt1), 32'd1);
      chk("t1_end_src", 32'(out_src), 32'd1);

      // Requester 0 back-to-back against waiting requester 1: grants go 0,1,0.
      drv(0, 1'b1, "p", 1'b0);
      drv(1, 1'b1, "u", 1'b0);
      tick();
      send(0, "p", 1'b0, 1'b0, "t2p");
      send(0, "q", 1'b1, 1'b1, "t2q");
      drv(0, 1'b1, "r", 1'b0);
      #1;
      chk("t2_bub_rdy0", 32'(in0_ready), 32'd0);
      chk("t2_bub_ovld", 32'(out_valid), 32'd0);
      tick();
      send(1, "u", 1'b0, 1'b0, "t2u");
      send(1, "v", 1'b1, 1'b1, "t2v");
      drv(1, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t2_bub2_rdy0", 32'(in0_ready), 32'd0);
      tick();
      send(0, "r", 1'b0, 1'b0, "t2r");
      send(0, "s", 1'b1, 1'b1, "t2s");
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t2_cnt0", 32'(str_cnt0), 32'd3);
      chk("t2_cnt1", 32'(str_cnt1), 32'd2);

      // 20-char string from requester 0: 16 forwarded, trunc pulse, 4 dropped.
      drv(0, 1'b1, 8'h41, 1'b0);
      tick();
      for (int i = 1; i <= 16; i++) send(0, 8'(64 + i), 1'b0, (i == 16), "t3");
      drv(0, 1'b1, 8'h51, 1'b0);
      #1;
      chk("t3_trunc",   32'(trunc), 32'd1);
      chk("t3_drp_busy", 32'(busy), 32'd1);
      chk("t3_drp_ovld", 32'(out_valid), 32'd0);
      chk("t3_drp_rdy0", 32'(in0_ready), 32'd1);
      chk("t3_cnt0",    32'(str_cnt0), 32'd4);
      tick();
      drv(0, 1'b1, 8'h52, 1'b0);
      #1;
      chk("t3_trunc_off", 32'(trunc), 32'd0);
      chk("t3_drp2_ovld", 32'(out_valid), 32'd0);
      tick();
      drv(0, 1'b1, 8'h53, 1'b0);
      tick();
      drv(0, 1'b1, 8'h54, 1'b1);
      #1;
      chk("t3_drp4_rdy0", 32'(in0_ready), 32'd1);
      chk("t3_drp4_busy", 32'(busy), 32'd1);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t3_end_busy", 32'(busy), 32'd0);
      chk("t3_end_cnt0", 32'(str_cnt0), 32'd4);

      // Exactly 16 chars from requester 1: no truncation.
      drv(1, 1'b1, 8'h61, 1'b0);
      tick();
      for (int i = 1; i <= 16; i++) send(1, 8'(96 + i), (i == 16), (i == 16), "t4");
      drv(1, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t4_trunc", 32'(trunc), 32'd0);
      chk("t4_busy",  32'(busy), 32'd0);
      chk("t4_cnt1",  32'(str_cnt1), 32'd3);
      chk("t4_src",   32'(out_src), 32'd1);

      // out_ready toggling mid-string.
      drv(0, 1'b1, "k", 1'b0);
      tick();
      send(0, "k", 1'b0, 1'b0, "t5k");
      drv(0, 1'b1, "l", 1'b0);
      out_ready = 1'b0;
      #1;
      chk("t5_stall_rdy0", 32'(in0_ready), 32'd0);
      chk("t5_stall_ovld", 32'(out_valid), 32'd1);
      chk("t5_stall_data", 32'(out_data), 32'(8'h6c));
      tick();
      out_ready = 1'b1;
      #1;
      chk("t5_go_rdy0", 32'(in0_ready), 32'd1);
      chk("t5_go_data", 32'(out_data), 32'(8'h6c));
      chk("t5_go_last", 32'(out_last), 32'd0);
      tick();
      out_ready = 1'b0;
      drv(0, 1'b1, "m", 1'b1);
      #1;
      chk("t5_stall2_rdy0", 32'(in0_ready), 32'd0);
      chk("t5_stall2_last", 32'(out_last), 32'd1);
      chk("t5_stall2_data", 32'(out_data), 32'(8'h6d));
      tick();
      out_ready = 1'b1;
      #1;
      chk("t5_go2_rdy0", 32'(in0_ready), 32'd1);
      chk("t5_go2_busy", 32'(busy), 32'd1);
      tick();
      drv(0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("t5_end_busy", 32'(busy), 32'd0);
      chk("t5_end_cnt0", 32'(str_cnt0), 32'd5);

      // Reset on char 2 of a 5-char string.
      drv(0, 1'b1, "1", 1'b0);
      tick();
      send(0, "1", 1'b0, 1'b0, "t6c1");
      drv(0, 1'b1, "2", 1'b0);
      rst = 1'b1;
      #1;
      chk("t6_rst_ovld", 32'(out_valid), 32'd0);
      chk("t6_rst_rdy0", 32'(in0_ready), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_src",  32'(out_src), 32'd1);
      tick();
      rst = 1'b0;
      drv(0, 1'b1, "1", 1'b0);
      drv(1, 1'b1, "9", 1'b0);
      #1;
      chk("t6_busy",  32'(busy), 32'd0);
      chk("t6_cnt0",  32'(str_cnt0), 32'd0);
      chk("t6_cnt1",  32'(str_cnt1), 32'd0);
      chk("t6_trunc", 32'(trunc), 32'd0);
      chk("t6_ovld",  32'(out_valid), 32'd0);
      tick();
      #1;
      chk("t6_gnt_src",  32'(out_src), 32'd0);
      chk("t6_gnt_rdy0", 32'(in0_ready), 32'd1);
      chk("t6_gnt_rdy1", 32'(in1_ready), 32'd0);
      chk("t6_gnt_data", 32'(out_data), 32'(8'h31));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/string_arbiter.md
STRING_ARBITER -- requirements
Module: string_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: character width in bits.
REQ-002 Parameter MAX_LEN, default 16: maximum characters per string, legal range 2..255.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 in0_valid/in1_valid  input  1 each: requester n presents a character.
REQ-006 in0_ready/in1_ready  output  1 each: arbiter accepts requester n's character this cycle.
REQ-007 in0_data/in1_data  input  DATA_W each: character from requester n.
REQ-008 in0_last/in1_last  input  1 each: marks the final character of requester n's string.
REQ-009 out_valid  output  1: character presented to the shared string datapath.
REQ-010 out_ready  input  1: datapath accepts the character.
REQ-011 out_data  output  DATA_W: forwarded character.
REQ-012 out_last  output  1: final character of the forwarded string.
REQ-013 out_src  output  1: index of the currently granted requester.
REQ-014 busy  output  1: high in any state other than IDLE.
REQ-015 trunc  output  1: one-cycle pulse when a string is truncated at MAX_LEN.
REQ-016 str_cnt0/str_cnt1  output  16 each: completed strings forwarded per requester.

Function
REQ-017 The FSM SHALL have states IDLE, GRANT0, GRANT1, DROP.
REQ-018 A handshake occurs on a port when its valid and ready are both high in the same cycle.
REQ-019 IDLE: all in_ready=0, out_valid=0; on the next edge, go to GRANTn for the single requester with in_valid high; with both high, grant the requester not last granted; with none high, stay in IDLE.
REQ-020 Arbitration is registered: one bubble cycle in IDLE precedes every grant; grants are per whole string, never per character.
REQ-021 GRANTn: out_valid=in_valid[n], out_data=in_data[n], in_ready[n]=out_ready, in_ready of the other requester=0, out_src=n; the data path is combinational with zero latency.
REQ-022 A length counter (8 bit) SHALL clear on entering GRANTn and increment on each out handshake.
REQ-023 out_last = in_last[n] OR (len == MAX_LEN-1) while in GRANTn; otherwise 0.
REQ-024 An out handshake with in_last[n]=1 SHALL return the FSM to IDLE, record n as last granted, and increment str_cnt[n].
REQ-025 An out handshake with len==MAX_LEN-1 and in_last[n]=0 SHALL assert trunc for exactly the next cycle, increment str_cnt[n], record n as last granted, and go to DROP.
REQ-026 DROP: in_ready[n]=1 for the truncated requester, out_valid=0; characters are discarded; a handshake with in_last[n]=1 returns to IDLE.
REQ-027 A string of exactly MAX_LEN characters with in_last on character MAX_LEN is not truncated: no trunc pulse and no DROP.
REQ-028 out_src SHALL hold the last granted index in IDLE.
REQ-029 str_cnt0/str_cnt1 SHALL wrap from 0xFFFF to 0x0000.
REQ-030 in_valid without a grant SHALL be held by the requester; the arbiter never drops characters outside DROP.

Reset
REQ-031 With rst high at an edge: state=IDLE, last granted=1 (requester 0 wins first contention), len=0, str_cnt0=str_cnt1=0, trunc=0.
REQ-032 During reset and the cycle after: out_valid=0, in_ready=0, busy=0, out_src=1.
REQ-033 Reset asserted mid-string SHALL abandon the string with no counter increment and no trunc pulse.

Verification
REQ-034 Both requesters raise valid together, each with a 3-char string "abc"/"xyz", out_ready=1 -> out stream "abc" (src 0), one IDLE bubble, then "xyz" (src 1); str_cnt0=1, str_cnt1=1.
REQ-035 Requester 0 sends back-to-back strings while requester 1 waits -> strings alternate 0,1,0 and no requester is granted twice in a row under contention.
REQ-036 MAX_LEN=16, requester 0 sends 20 chars with last on char 20 -> 16 chars out, out_last on char 16, one trunc pulse, 4 chars dropped, str_cnt0=1.
REQ-037 A 16-char string with last on char 16 -> out_last on char 16, trunc stays 0, FSM returns to IDLE.
REQ-038 out_ready toggles 1,0,1,0 mid-string -> in_ready mirrors it, out_data holds stable while stalled, and no character is duplicated or lost.
REQ-039 Assert rst at char 2 of a 5-char string -> next cycle busy=0, counters=0, and a new contention grants requester 0.
